// File: rtl/psx_poll_scheduler.sv
// rtl/psx_poll_scheduler.sv - PSX poll sequencer with coherent button hand-off to the N64 side
// A free-running period tick requests polls; results are committed only while the N64 side is idle.
module psx_poll_scheduler #(
    parameter int POLL_PERIOD = 16000,
    parameter int TIMEOUT     = 4000,
    parameter int MAX_MISSES  = 3,
    parameter int CNT_W       = 16
) (
    input  logic        sample_clk,
    input  logic        rst_n,
    input  logic [15:0] psx_btns_in,
    input  logic        psx_done,
    input  logic        n64_busy,
    output logic        psx_start,
    output logic [15:0] btns_out,
    output logic        link_ok,
    output logic        overrun
);

    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(POLL_PERIOD - 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(TIMEOUT - 1);
    localparam logic [3:0]       MISS_MAX    = 4'(MAX_MISSES);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        COMMIT
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] tmo_q;
    logic             pending_q, pending_d;
    logic             overrun_q, overrun_d;
    logic [3:0]       miss_q;
    logic [3:0]       miss_inc;
    logic [15:0]      shadow_q;
    logic [15:0]      btns_q;
    logic             start_q;
    logic             link_q;
    logic             tick;
    logic             take;

    assign tick     = (period_q == PERIOD_LAST);
    assign take     = (state_q == IDLE) && pending_q;
    assign miss_inc = (miss_q == MISS_MAX) ? miss_q : miss_q + 4'd1;

    // A tick in the cycle the FSM consumes the request simply re-arms pending.
    always_comb begin
        period_d  = tick ? '0 : period_q + 1'b1;
        pending_d = pending_q;
        overrun_d = overrun_q;
        if (tick) begin
            pending_d = 1'b1;
            if (pending_q && !take) begin
                overrun_d = 1'b1;
            end
        end else if (take) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge sample_clk or negedge rst_n) begin
        if (!rst_n) begin
            period_q  <= '0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            period_q  <= period_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge sample_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            tmo_q    <= '0;
            miss_q   <= '0;
            shadow_q <= 16'hFFFF;
            btns_q   <= 16'hFFFF;
            start_q  <= 1'b0;
            link_q   <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pending_q) begin
                        state_q <= START;
                        start_q <= 1'b1;
                    end
                end
                START: begin
                    tmo_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    tmo_q <= tmo_q + 1'b1;
                    if (psx_done) begin
                        shadow_q <= psx_btns_in;
                        miss_q   <= '0;
                        link_q   <= 1'b1;
                        state_q  <= COMMIT;
                    end else if (tmo_q == TMO_LAST) begin
                        miss_q <= miss_inc;
                        if (miss_inc == MISS_MAX) begin
                            shadow_q <= 16'hFFFF;
                            link_q   <= 1'b0;
                            state_q  <= COMMIT;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                COMMIT: begin
                    // Hold the old state for as long as the N64 reply is in flight.
                    if (!n64_busy) begin
                        btns_q  <= shadow_q;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign psx_start = start_q;
    assign btns_out  = btns_q;
    assign link_ok   = link_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_psx_poll_scheduler.sv
// tb/tb_psx_poll_scheduler.sv - scoreboard bench for psx_poll_scheduler
module tb_psx_poll_scheduler;

    localparam int P = 20;
    localparam int T = 8;
    localparam int M = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] btns_in;
    logic        done;
    logic        busy;
    logic        start;
    logic [15:0] btns;
    logic        link;
    logic        ov;

    psx_poll_scheduler #(
        .POLL_PERIOD(P),
        .TIMEOUT    (T),
        .MAX_MISSES (M),
        .CNT_W      (16)
    ) dut (
        .sample_clk (clk),
        .rst_n      (rst_n),
        .psx_btns_in(btns_in),
        .psx_done   (done),
        .n64_busy   (busy),
        .psx_start  (start),
        .btns_out   (btns),
        .link_ok    (link),
        .overrun    (ov)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [15:0] val;
        logic        lnk;
        logic        ovr;
    } ev_t;

    ev_t         exp_start[$];
    ev_t         exp_btns[$];
    int          plan_d[$];
    int          plan_b[$];
    logic [15:0] plan_btn[$];

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic ev_t mk(input int c, input logic [15:0] v, input logic l, input logic o);
        ev_t e;
        e.cyc = c; e.val = v; e.lnk = l; e.ovr = o;
        return e;
    endfunction

    function automatic int first_tick(input int from);
        int t = P - 1;
        while (t < from) t += P;
        return t;
    endfunction

    // Event-level model: period ticks at k*P+P-1 (counted from release), pending seen
    // one cycle later, poll starts the cycle after the FSM picks it up while idle.
    task automatic build_expect(input int abort_ofs, output int abort_cyc);
        int lc = 0, tfree = 0, miss = 0, ovt = 1 << 30;
        int c, tn, s, x, d, b;
        logic lnk = 1'b0;
        logic [15:0] cur = 16'hFFFF;
        logic [15:0] val;
        bit commit;
        abort_cyc = 0;
        exp_start.delete();
        exp_btns.delete();
        foreach (plan_d[i]) begin
            tn = first_tick(lc);
            c  = (tfree > tn + 1) ? tfree : tn + 1;
            if (tn + P <= c - 1 && tn + P + 1 < ovt) ovt = tn + P + 1;
            lc = c;
            s  = c + 1;
            d  = plan_d[i];
            b  = plan_b[i];
            abort_cyc = s + abort_ofs;
            exp_start.push_back(mk(s, 16'h0, lnk, 1'b0));
            commit = 1'b0;
            val = cur;
            x = 0;
            if (d <= T) begin
                lnk = 1'b1; miss = 0; val = plan_btn[i];
                x = s + d + 2 + b; commit = 1'b1;
            end else begin
                if (miss < M) miss++;
                if (miss == M) begin
                    lnk = 1'b0; val = 16'hFFFF;
                    x = s + T + 2 + b; commit = 1'b1;
                end else begin
                    tfree = s + T + 1;
                end
            end
            if (commit) begin
                tfree = x;
                if (val != cur)
                    exp_btns.push_back(mk(x, val, lnk, (ovt <= x) || (first_tick(lc) + P + 1 <= x)));
                cur = val;
            end
        end
        while (exp_start.size() > 0 && exp_start[$].cyc >= abort_cyc) void'(exp_start.pop_back());
        while (exp_btns.size() > 0 && exp_btns[$].cyc >= abort_cyc) void'(exp_btns.pop_back());
    endtask

    // PSX/N64 emulator: answers each psx_start per plan, injects psx_done noise outside WAIT.
    int pi = 0, win_start = 0, win_end = -1, done_at = -1, bs = 0, be = 0;
    logic [15:0] ans_btn = 16'hFFFF;
    always @(negedge clk) begin
        bit in_win;
        if (!rst_n) begin
            done = 1'b0; busy = 1'b0; btns_in = 16'($urandom());
            pi = 0; win_start = 0; win_end = -1; done_at = -1; bs = 0; be = 0;
        end else begin
            if (start && pi < plan_d.size()) begin
                win_start = cyc + 1;
                ans_btn   = plan_btn[pi];
                if (plan_d[pi] <= T) begin
                    done_at = cyc + plan_d[pi]; win_end = done_at; bs = done_at + 1;
                end else begin
                    done_at = -1; win_end = cyc + T; bs = cyc + T + 1;
                end
                be = bs + plan_b[pi];
                pi++;
            end
            in_win = (cyc >= win_start) && (cyc <= win_end);
            if (cyc == done_at) begin
                done = 1'b1; btns_in = ans_btn;
            end else if (!in_win && $urandom_range(0, 5) == 0) begin
                done = 1'b1; btns_in = 16'($urandom());
            end else begin
                done = 1'b0; btns_in = 16'($urandom());
            end
            busy = (cyc >= bs && cyc < be) || (in_win && $urandom_range(0, 1) == 1);
        end
    end

    logic [15:0] prev_btns = 16'hFFFF;
    always @(negedge clk) begin
        ev_t e;
        if (!rst_n) begin
            prev_btns = 16'hFFFF;
        end else if (mon_en) begin
            if (start) begin
                if (exp_start.size() == 0) chk("start_unexpected_cycle", cyc, 32'hFFFFFFFF);
                else begin
                    e = exp_start.pop_front();
                    chk("start_cycle", cyc, e.cyc);
                    chk("start_link_ok", {31'b0, link}, {31'b0, e.lnk});
                end
            end
            if (btns != prev_btns) begin
                if (exp_btns.size() == 0) chk("btns_unexpected_change", {16'b0, btns}, {16'b0, prev_btns});
                else begin
                    e = exp_btns.pop_front();
                    chk("btns_cycle", cyc, e.cyc);
                    chk("btns_value", {16'b0, btns}, {16'b0, e.val});
                    chk("btns_link_ok", {31'b0, link}, {31'b0, e.lnk});
                    chk("btns_overrun", {31'b0, ov}, {31'b0, e.ovr});
                end
            end
            prev_btns = btns;
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_psx_start"}, {31'b0, start}, 0);
        chk({tag, "_btns_out"}, {16'b0, btns}, 32'hFFFF);
        chk({tag, "_link_ok"}, {31'b0, link}, 0);
        chk({tag, "_overrun"}, {31'b0, ov}, 0);
    endtask

    task automatic add_plan(input int d, input int b, input logic [15:0] v);
        plan_d.push_back(d); plan_b.push_back(b); plan_btn.push_back(v);
    endtask

    task automatic add_random(input int n);
        for (int i = 0; i < n; i++) begin
            int d, b;
            d = ($urandom_range(0, 9) < 6) ? int'($urandom_range(1, T)) : T + 1;
            b = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 25));
            add_plan(d, b, 16'($urandom()));
        end
    endtask

    task automatic run_session(input int abort_ofs, input string tag);
        int a;
        int guard = 0;
        build_expect(abort_ofs, a);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs({tag, "_in_reset"});
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        do begin
            @(posedge clk);
            #2;
            guard++;
        end while (cyc < a && guard < 20000);
        chk({tag, "_abort_reached"}, cyc, a);
        rst_n = 1'b0;
        #1 check_reset_outputs({tag, "_after_abort"});
        mon_en = 1'b0;
        chk({tag, "_start_events_left"}, exp_start.size(), 0);
        chk({tag, "_btns_events_left"}, exp_btns.size(), 0);
    endtask

    initial begin
        done = 1'b0; busy = 1'b0; btns_in = 16'hFFFF;

        plan_d.delete(); plan_b.delete(); plan_btn.delete();
        add_plan(5, 0, 16'hFFBF);
        add_plan(5, 30, 16'hFFFE);
        add_plan(T + 1, 0, 16'h0000);
        add_plan(T + 1, 0, 16'h0000);
        add_plan(T + 1, 3, 16'h0000);
        add_plan(T, 0, 16'h7FFF);
        add_random(30);
        add_plan(T + 3, 0, 16'h0F0F);
        run_session(3, "wait_abort");

        plan_d.delete(); plan_b.delete(); plan_btn.delete();
        add_random(15);
        add_plan(2, 40, 16'h1234);
        run_session(10, "commit_abort");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
